lsu_mem_port: RTL
=================

# lsu_mem_port

Load/store port sitting directly upstream of the 512×32 word-wide data memory. Accepts one byte-addressed RV32 load or store per request and converts it to word-addressed memory traffic. Sub-word stores use read-modify-write, because the memory has one write enable and no byte enables. Load data is byte/half-lane extracted and sign/zero-extended before it is returned to the core.

## Interface
- MEM_LATENCY, 2: clock edges from `mem_addr` first driven to `mem_data_out` valid. The memory registers both its input and its output.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  port can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  single-cycle completion pulse; no back-pressure
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  illegal funct3 or trapped misalignment
- mem_write_enable  out  1  to memory `write_enable`
- mem_addr  out  32  word index, equal to `{2'b0, addr[31:2]}`
- mem_data_in  out  32  to memory `data_in`
- mem_data_out  in  32  from memory `data_out`

## Operation
- States: IDLE, RD_WAIT, RMW_WR, WR, RESP.
- A request is accepted when `req_valid && req_ready`. All request fields are captured at that edge.
- Acceptance from IDLE goes to:
  - WR, for SW.
  - RD_WAIT, for loads, SB and SH. A counter is loaded with MEM_LATENCY.
  - RESP with error, for an illegal funct3 or a trapped misalignment. No memory access occurs.
- RD_WAIT: counts down. At zero, the next state is RESP (load) or RMW_WR (store).
  - Load: `resp_rdata` is registered from `mem_data_out` using lane `addr[1:0]` and sign/zero extension per funct3.
  - Store: the merged word is computed.
- RMW_WR: drives the merged word with `mem_write_enable`=1 for exactly one cycle, then goes to RESP.
  - SB replaces byte `addr[1:0]`.
  - SH replaces half `addr[1]`.
- WR: drives `req_wdata` with `mem_write_enable`=1 for one cycle, then goes to RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE.
- `mem_addr` holds the captured word index from acceptance until the next acceptance.
- `mem_write_enable` is never high outside WR or RMW_WR.
- Memory-side outputs are all registered.
- Illegal funct3 for a store (anything other than 000, 001 or 010) raises an error.
- Upper address bits beyond the memory depth alias; they are not checked.

## Timing
- Acceptance edge is E0.
- Load: address is stable after E0 and data is valid after E(MEM_LATENCY). `resp_valid` is high in the cycle after E(MEM_LATENCY+1), i.e. E3 by default.
- SW: `mem_write_enable` is high after E0, and memory writes at E1. `resp_valid` is high after E1.
- SB/SH: `mem_write_enable` is high after E(MEM_LATENCY+1), and memory writes at E(MEM_LATENCY+2). `resp_valid` is high after E4 by default.
- Error: `resp_valid` and `resp_error` are high after E0.
- `req_ready` is 1 only in IDLE.
- The next request may be accepted the cycle after RESP.
- Reset (`rst_n` low, at any time):
  - Immediately: state=IDLE, `req_ready`=0, `resp_valid`=0, `resp_error`=0, `resp_rdata`=0, `mem_write_enable`=0, `mem_addr`=0, `mem_data_in`=0.
  - Any in-flight RMW that has not reached its write edge is abandoned; memory contents are untouched.
  - `req_ready` returns to 1 on the first edge after release.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Conditions: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Response: `resp_error`=1 with no memory access.
- MISALIGN_TRAP_EN undefined:
  - Offending low bits are treated as 0 (aligned down).
  - The access proceeds normally with `resp_error`=0.
- Illegal-funct3 errors exist in both builds.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams.
  - State enum.
  - The MEM_LATENCY default.
- Sub-module `lsu_lane_align`, purely combinational:
  - Load extract and extend.
  - Store byte/half merge.
- The FSM, counter and registers live in `lsu_mem_port`.
- The bench instantiates the existing memory downstream.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 -> `rdata`=0xDEADBEEF; `resp_valid` exactly 3 edges after accept.
- SB 0xAA @0x11 -> LW @0x10 = 0xDEADAAEF; LB @0x11 = 0xFFFFFFAA; LBU @0x11 = 0x000000AA; one write pulse only.
- SH 0x8001 @0x12 -> LW @0x10 = 0x8001AAEF; LH @0x12 = 0xFFFF8001; LHU @0x12 = 0x00008001.
- LW @0x13:
  - With MISALIGN_TRAP_EN -> `resp_error`=1 after 1 edge; no `mem_write_enable`.
  - Without -> returns the word @0x10.
- SB during RD_WAIT, then `rst_n` pulsed low -> no write pulse; all outputs 0; word unchanged on a subsequent LW.
- Request with funct3=011 -> `resp_error`=1, `rdata`=0, memory untouched; back-to-back next request accepted the cycle after RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// +------------------------------------------------------------------------+
// | lsu_pkg : shared funct3 codes, FSM states and latency for the LSU port  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam int MEM_LATENCY = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RMW_WR  = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // Stores only know B/H/W; the unsigned codes are load-only.
  function automatic logic funct3_legal(input logic is_write, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_write) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_port_lane_align.sv
// +------------------------------------------------------------------------+
// | lsu_lane_align : load lane extract/extend and sub-word store merge      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (offset[1]) merged[31:16] = wdata;
        else           merged[15:0]  = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_port.sv
// +------------------------------------------------------------------------+
// | lsu_mem_port : RV32 byte-addressed load/store to word memory with RMW   |
// | Revision: 1.0   Option: MISALIGN_TRAP_EN traps misaligned H/W accesses |
// +------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = lsu_pkg::MEM_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_error_q, resp_error_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_in_q, mem_data_in_d;

  logic               accept;
  logic               is_half, is_word;
  logic               req_misaligned;
  logic               req_err;
  logic [1:0]         req_off;
  logic [31:0]        load_data;
  logic [31:0]        merged;

  assign accept  = req_valid && req_ready_q;
  assign is_half = (req_funct3[1:0] == 2'b01);
  assign is_word = (req_funct3[1:0] == 2'b10);

  // Low address bits are dropped to the natural alignment; in the trap build
  // an aligned access already has them at zero, so one formula serves both.
  always_comb begin
    if (is_word)      req_off = 2'b00;
    else if (is_half) req_off = {req_addr[1], 1'b0};
    else              req_off = req_addr[1:0];
  end

`ifdef MISALIGN_TRAP_EN
  assign req_misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_err = !funct3_legal(req_write, req_funct3) || req_misaligned;

  lsu_lane_align u_align (
    .funct3    (funct3_q),
    .offset    (off_q),
    .word      (mem_data_out),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    wdata_d       = wdata_q;
    resp_valid_d  = 1'b0;
    resp_error_d  = resp_error_q;
    resp_rdata_d  = resp_rdata_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d      = req_write;
          funct3_d     = req_funct3;
          off_d        = req_off;
          wdata_d      = req_wdata[15:0];
          mem_addr_d   = {2'b00, req_addr[31:2]};
          resp_rdata_d = 32'h0;
          resp_error_d = 1'b0;
          if (req_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_write && (req_funct3 == F3_W)) begin
            state_d       = ST_WR;
            mem_we_d      = 1'b1;
            mem_data_in_d = req_wdata;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_W'(MEM_LATENCY);
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            state_d       = ST_RMW_WR;
            mem_we_d      = 1'b1;
            mem_data_in_d = merged;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RMW_WR, ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      wdata_q       <= 16'h0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_data_in_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = resp_rdata_q;
  assign mem_write_enable = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_data_in      = mem_data_in_q;

endmodule

`default_nettype wire
